// File: rtl/cpu_pkg.sv
// cpu_pkg: definitions shared by the program loader and its word assembler.
//   ld_state_e  : loader FSM state encoding
//   ERR_*       : err_code values reported by the loader
//   SYNC_BYTE_DEF : default frame start byte
package cpu_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEN0  = 3'd1,
      ST_LEN1  = 3'd2,
      ST_DATA  = 3'd3,
      ST_CSUM  = 3'd4,
      ST_DONE  = 3'd5,
      ST_ERROR = 3'd6
   } ld_state_e;

   localparam logic [1:0] ERR_NONE    = 2'd0;
   localparam logic [1:0] ERR_LENGTH  = 2'd1;
   localparam logic [1:0] ERR_CSUM    = 2'd2;
   localparam logic [1:0] ERR_TIMEOUT = 2'd3;

   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

endpackage

// File: rtl/word_assembler_v.sv
// word_assembler_v: packs a little-endian byte stream into 32-bit words.
//   clk, reset   : clock, synchronous active-high reset
//   clr          : start of a new frame (clears index, sum, pending word)
//   byte_en      : byte_in is consumed this cycle
//   byte_in      : data byte
//   last_byte    : byte_en on the 4th byte of a word (combinational)
//   word         : assembled word, stable while word_valid is high
//   word_valid   : one-cycle pulse the cycle after a word's 4th byte
//   sum          : running mod-256 sum of consumed bytes
module word_assembler_v
   import cpu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clr,
   input  logic        byte_en,
   input  logic [7:0]  byte_in,
   output logic        last_byte,
   output logic [31:0] word,
   output logic        word_valid,
   output logic [7:0]  sum
);

   logic [1:0] byte_idx;

   assign last_byte = byte_en && (byte_idx == 2'd3);

   always_ff @(posedge clk) begin
      if (reset) begin
         byte_idx   <= '0;
         word       <= '0;
         word_valid <= 1'b0;
         sum        <= '0;
      end else if (clr) begin
         byte_idx   <= '0;
         word_valid <= 1'b0;
         sum        <= '0;
      end else begin
         word_valid <= last_byte;
         if (byte_en) begin
            // LSB first: after four shifts the first byte sits in [7:0].
            // A byte accepted in the write cycle shifts only at its end,
            // so the word presented with word_valid is still intact.
            word     <= {byte_in, word[31:8]};
            byte_idx <= byte_idx + 2'd1;
            sum      <= sum + byte_in;
         end
      end
   end

endmodule

// File: rtl/imem_loader_v.sv
// imem_loader_v: framed byte-stream program loader, writer side of the
// IF-stage instruction memory.
//   clk, reset          : clock, synchronous active-high reset
//   rx_data/valid/ready : byte input, transfer on valid & ready
//   imem_we/addr/wdata  : instruction memory write port, one word per strobe
//   cpu_hold            : holds the CPU in reset while loading / after failure
//   load_busy           : frame in progress
//   load_done, load_err : one-cycle end-of-frame pulses
//   err_code            : sticky cause of the last failure, cleared on SYNC
//   words_loaded        : words written in the current/last frame
module imem_loader_v
   import cpu_pkg::*;
#(
   parameter int         ADDR_W         = 10,
   parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
   parameter int         TIMEOUT_CYCLES = 100000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [7:0]        rx_data,
   input  logic              rx_valid,
   output logic              rx_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [31:0]       imem_wdata,
   output logic              cpu_hold,
   output logic              load_busy,
   output logic              load_done,
   output logic              load_err,
   output logic [1:0]        err_code,
   output logic [ADDR_W:0]   words_loaded
);

   localparam int          TW    = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

   ld_state_e         state, state_nxt;
   logic [15:0]       len_q;
   logic [ADDR_W:0]   wcnt;
   logic [ADDR_W-1:0] addr;
   logic [TW-1:0]     tcnt;

   logic        accept, tmo, sync_hit, byte_en, last_byte, word_valid;
   logic        err_set, done_set;
   logic [1:0]  err_val;
   logic [15:0] len_in;
   logic [7:0]  sum;
   logic [31:0] word;

   assign accept   = rx_valid && rx_ready;
   assign len_in   = {rx_data, len_q[7:0]};
   assign sync_hit = (state == ST_IDLE) && accept && (rx_data == SYNC_BYTE);
   assign tmo      = (state inside {ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM})
                     && (tcnt == TW'(TIMEOUT_CYCLES - 1));
   // A byte arriving on the timeout edge is dropped: timeout wins.
   assign byte_en  = accept && (state == ST_DATA) && !tmo;

   word_assembler_v u_asm (
      .clk        (clk),
      .reset      (reset),
      .clr        (sync_hit),
      .byte_en    (byte_en),
      .byte_in    (rx_data),
      .last_byte  (last_byte),
      .word       (word),
      .word_valid (word_valid),
      .sum        (sum)
   );

   // The final word is written in the first CSUM cycle; hold off the
   // checksum byte that cycle so the write completes on its own.
   always_comb begin
      rx_ready = 1'b0;
      if (!reset)
         rx_ready = (state inside {ST_IDLE, ST_LEN0, ST_LEN1, ST_DATA, ST_CSUM})
                    && !((state == ST_CSUM) && word_valid);
   end

   always_comb begin
      state_nxt = state;
      err_set   = 1'b0;
      err_val   = ERR_NONE;
      done_set  = 1'b0;
      case (state)
         ST_IDLE: if (sync_hit) state_nxt = ST_LEN0;
         ST_LEN0: begin
            if (tmo) begin
               state_nxt = ST_ERROR; err_set = 1'b1; err_val = ERR_TIMEOUT;
            end else if (accept) state_nxt = ST_LEN1;
         end
         ST_LEN1: begin
            if (tmo) begin
               state_nxt = ST_ERROR; err_set = 1'b1; err_val = ERR_TIMEOUT;
            end else if (accept) begin
               if ({1'b0, len_in} > DEPTH) begin
                  state_nxt = ST_ERROR; err_set = 1'b1; err_val = ERR_LENGTH;
               end else if (len_in == 16'd0) state_nxt = ST_CSUM;
               else                          state_nxt = ST_DATA;
            end
         end
         ST_DATA: begin
            if (tmo) begin
               state_nxt = ST_ERROR; err_set = 1'b1; err_val = ERR_TIMEOUT;
            end else if (last_byte && (16'(wcnt) + 16'd1 == len_q))
               state_nxt = ST_CSUM;
         end
         ST_CSUM: begin
            if (tmo) begin
               state_nxt = ST_ERROR; err_set = 1'b1; err_val = ERR_TIMEOUT;
            end else if (accept) begin
               if (rx_data == sum) state_nxt = ST_DONE;
               else begin
                  state_nxt = ST_ERROR; err_set = 1'b1; err_val = ERR_CSUM;
               end
            end
         end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            done_set  = 1'b1;
         end
         ST_ERROR: state_nxt = ST_IDLE;
         default:  state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         len_q        <= '0;
         wcnt         <= '0;
         addr         <= '0;
         tcnt         <= '0;
         cpu_hold     <= 1'b0;
         err_code     <= ERR_NONE;
         words_loaded <= '0;
      end else begin
         if (state == ST_IDLE || accept) tcnt <= '0;
         else                            tcnt <= tcnt + TW'(1);

         if (state == ST_LEN0 && accept) len_q[7:0]  <= rx_data;
         if (state == ST_LEN1 && accept) len_q[15:8] <= rx_data;

         if (sync_hit) begin
            cpu_hold     <= 1'b1;
            err_code     <= ERR_NONE;
            words_loaded <= '0;
            addr         <= '0;
            wcnt         <= '0;
         end else begin
            if (last_byte) wcnt <= wcnt + 1'b1;
            if (word_valid) begin
               addr         <= addr + 1'b1;
               words_loaded <= words_loaded + 1'b1;
            end
            if (err_set)  err_code <= err_val;
            if (done_set) cpu_hold <= 1'b0;
         end
      end
   end

   assign imem_we    = word_valid;
   assign imem_addr  = addr;
   assign imem_wdata = word;
   assign load_busy  = (state != ST_IDLE);
   assign load_done  = (state == ST_DONE);
   assign load_err   = (state == ST_ERROR);

endmodule

// File: tb/tb_imem_loader_v.sv
module tb_imem_loader_v;

   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset;
   logic [7:0]    rx_data;
   logic          rx_valid;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_hold, load_busy, load_done, load_err;
   logic [1:0]    err_code;
   logic [AW:0]   words_loaded;

   imem_loader_v #(.ADDR_W(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
      .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .load_busy(load_busy),
      .load_done(load_done), .load_err(load_err), .err_code(err_code),
      .words_loaded(words_loaded)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int          exp_addr[$];
   logic [31:0] exp_data[$];
   int          wr_cyc[$];
   logic [31:0] wbuf[8];

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   // Scoreboard: each write strobe pops one expected {addr,data}.
   always @(negedge clk) begin
      cyc++;
      if (imem_we) begin
         wr_cyc.push_back(cyc);
         if (exp_data.size() == 0) chk("wr_unexpected", 32'(imem_addr), 32'hFFFF_FFFF);
         else begin
            chk("wr_addr", 32'(imem_addr), 32'(exp_addr.pop_front()));
            chk("wr_data", imem_wdata, exp_data.pop_front());
         end
      end
      if (load_done) done_cnt++;
      if (load_err)  err_cnt++;
   end

   // Called at a negedge; returns at the negedge after the accepting posedge.
   task automatic send(input logic [7:0] b);
      int n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("ready_stuck", 32'(rx_ready), 32'd1);
      @(negedge clk);
   endtask

   // 0: no end pulse in budget, 1: done, 2: error
   task automatic wait_end(output int kind);
      int d0 = done_cnt, e0 = err_cnt;
      kind = 0;
      for (int i = 0; i < 40 && kind == 0; i++) begin
         @(negedge clk);
         if (done_cnt != d0) kind = 1;
         else if (err_cnt != e0) kind = 2;
      end
      if (kind == 0) chk("end_timeout", 32'd0, 32'd1);
   endtask

   task automatic send_frame(input int n, input logic bad_csum, output int kind);
      logic [7:0] s = 8'h00;
      logic [31:0] w;
      send(8'hA5);
      send(8'(n));
      send(8'(n >> 8));
      for (int i = 0; i < n; i++) begin
         w = wbuf[i];
         exp_addr.push_back(i);
         exp_data.push_back(w);
         for (int k = 0; k < 4; k++) begin
            send(w[7:0]);
            s = s + w[7:0];
            w = w >> 8;
         end
      end
      send(bad_csum ? ~s : s);
      rx_valid = 1'b0;
      wait_end(kind);
   endtask

   initial begin
      int kind, k;
      logic [31:0] w;
      reset = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
      repeat (2) @(negedge clk);
      chk("rst_ready", 32'(rx_ready), 0);
      chk("rst_we", 32'(imem_we), 0);
      chk("rst_hold", 32'(cpu_hold), 0);
      chk("rst_busy", 32'(load_busy), 0);
      chk("rst_words", 32'(words_loaded), 0);
      reset = 1'b0;
      @(negedge clk);

      // Frame A: two words, good checksum (0xE0)
      wbuf[0] = 32'h0010_0513; wbuf[1] = 32'h0020_0593;
      send_frame(2, 1'b0, kind);
      chk("A_kind", kind, 1);
      chk("A_hold", 32'(cpu_hold), 0);
      chk("A_words", 32'(words_loaded), 2);
      chk("A_code", 32'(err_code), 0);
      chk("A_sb_empty", exp_data.size(), 0);

      // Same frame, bad checksum
      send_frame(2, 1'b1, kind);
      chk("B_kind", kind, 2);
      chk("B_code", 32'(err_code), 2);
      chk("B_hold", 32'(cpu_hold), 1);
      chk("B_words", 32'(words_loaded), 2);
      chk("B_sb_empty", exp_data.size(), 0);

      // Empty frame
      send_frame(0, 1'b0, kind);
      chk("N0_kind", kind, 1);
      chk("N0_words", 32'(words_loaded), 0);
      chk("N0_hold", 32'(cpu_hold), 0);

      // Length one past capacity
      send(8'hA5); send(8'h01); send(8'h04);
      rx_valid = 1'b0;
      chk("LEN_err_now", 32'(load_err), 1);
      wait_end(kind);
      chk("LEN_code", 32'(err_code), 1);
      chk("LEN_hold", 32'(cpu_hold), 1);
      chk("LEN_words", 32'(words_loaded), 0);

      // Timeout mid-DATA: one word + 2 bytes, then stall
      send(8'hA5); send(8'h02); send(8'h00);
      exp_addr.push_back(0); exp_data.push_back(32'hCAFE_F00D);
      send(8'h0D); send(8'hF0); send(8'hFE); send(8'hCA);
      send(8'h11); send(8'h22);
      rx_valid = 1'b0;
      k = 0;
      for (int i = 1; i <= 40 && k == 0; i++) begin
         @(negedge clk);
         if (load_err) k = i;
      end
      chk("TMO_cycle", k, 16);
      chk("TMO_code", 32'(err_code), 3);
      chk("TMO_words", 32'(words_loaded), 1);
      @(negedge clk);

      // Garbage then back-to-back three-word frame
      send(8'h00); send(8'hFF);
      chk("GB_idle", 32'(load_busy), 0);
      for (int i = 0; i < 3; i++) wbuf[i] = $urandom;
      wr_cyc.delete();
      send_frame(3, 1'b0, kind);
      chk("GB_kind", kind, 1);
      chk("GB_words", 32'(words_loaded), 3);
      chk("GB_nwr", wr_cyc.size(), 3);
      if (wr_cyc.size() == 3) begin
         chk("GB_gap0", wr_cyc[1] - wr_cyc[0], 4);
         chk("GB_gap1", wr_cyc[2] - wr_cyc[1], 4);
      end
      chk("GB_sb_empty", exp_data.size(), 0);

      // Reset mid-frame on the edge that would take word 1's last byte
      send(8'hA5); send(8'h04); send(8'h00);
      w = 32'h1234_5678;
      exp_addr.push_back(0); exp_data.push_back(w);
      for (int i = 0; i < 4; i++) send(w[8*i +: 8]);
      send(8'h01); send(8'h02); send(8'h03);
      rx_data = 8'h04; reset = 1'b1;
      @(negedge clk);
      chk("RM_busy", 32'(load_busy), 0);
      chk("RM_hold", 32'(cpu_hold), 0);
      chk("RM_ready", 32'(rx_ready), 0);
      chk("RM_words", 32'(words_loaded), 0);
      chk("RM_we", 32'(imem_we), 0);
      reset = 1'b0; rx_valid = 1'b0;
      repeat (10) @(negedge clk);
      chk("RM_sb_empty", exp_data.size(), 0);
      chk("RM_idle", 32'(load_busy), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/imem_loader_v.md
Name: imem_loader_v

Overview:
Byte-stream program loader. It is the writer side of the instruction memory that the pipeline's IF stage reads from.
- Accepts a framed program image over a valid/ready byte interface.
- Assembles little-endian 32-bit words and writes them sequentially into instruction memory.
- Holds the CPU pipeline in reset (cpu_hold) while a load is in progress.
- Sits beside the CPU top; its imem write port muxes into the IF-stage instruction memory.

Parameters:
ADDR_W, 10, instruction memory word-address width (depth 2^ADDR_W words).
SYNC_BYTE, 8'hA5, frame start byte.
TIMEOUT_CYCLES, 100000, max idle cycles between accepted bytes inside a frame.

Ports:
clk  in  1  system clock.
reset  in  1  synchronous, active-high reset.
rx_data  in  8  incoming byte.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  loader can accept a byte; transfer occurs when rx_valid & rx_ready at posedge.
imem_we  out  1  instruction-memory write strobe, one cycle per word.
imem_addr  out  ADDR_W  word address for the write.
imem_wdata  out  32  word to write.
cpu_hold  out  1  drive CPU reset; high while loading or after a failed load.
load_busy  out  1  frame in progress (state not IDLE).
load_done  out  1  one-cycle pulse on successful frame end.
load_err  out  1  one-cycle pulse on frame abort.
err_code  out  2  sticky: 0 none, 1 length, 2 checksum, 3 timeout; cleared on next SYNC.
words_loaded  out  ADDR_W+1  count of words written in the current/last frame.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Frame format: SYNC_BYTE, LEN_LO, LEN_HI (N = word count, 16 bit), then N×4 data bytes (LSB first per word), then CSUM.
- CSUM is the 8-bit sum mod 256 of the data bytes only.
- Reset values: state=IDLE, all outputs 0, rx_ready=0 during the reset cycle.
- States and transitions:
  - IDLE: non-SYNC bytes are accepted and discarded. SYNC → LEN0; on the same edge cpu_hold←1, err_code←0, words_loaded←0, addr←0, sum←0.
  - LEN0: latch the low byte → LEN1.
  - LEN1: latch the high byte.
    - N > 2^ADDR_W → ERROR (code 1).
    - N == 0 → CSUM.
    - else → DATA.
  - DATA: shift in bytes; sum += byte; byte index 0..3.
    - On the 4th byte, the next cycle has imem_we=1, imem_addr=addr, imem_wdata=assembled word; then addr++ and words_loaded++.
    - After the N-th word's 4th byte → CSUM.
  - CSUM: byte == sum → DONE, else ERROR (code 2).
  - DONE: one cycle; load_done=1, cpu_hold←0 → IDLE.
  - ERROR: one cycle; load_err=1, cpu_hold stays 1 → IDLE.
- rx_ready:
  - 1 in IDLE, LEN0, LEN1, DATA, CSUM.
  - 0 in DONE and ERROR.
  - 0 in the imem write cycle only when that cycle is the final word's write; otherwise the write overlaps with accepting the next byte.
- Write-latency rule: one cycle after the accepting edge of the word's last byte; writes never coalesce; at most one per cycle.
- Timeout:
  - Counter clears on every accepted byte and in IDLE.
  - In LEN0..CSUM, reaching TIMEOUT_CYCLES-1 with no transfer → ERROR (code 3).
  - Timeout has priority over a simultaneous transfer.
- SYNC inside a frame is treated as ordinary data; no resync.
- Words written before an error remain in memory; cpu_hold remains 1 until a later successful frame.
- Reset mid-frame: immediate return to IDLE, no pending write issued, cpu_hold←0.
- Address wrap: impossible, because the length check guarantees addr ≤ 2^ADDR_W-1 at the last write.

Decomposition:
- Shared package (cpu_pkg): loader state encoding (IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERROR), err_code constants, SYNC_BYTE default.
- One natural sub-module: word_assembler_v (byte shift register, 2-bit byte index, word_valid pulse, running 8-bit sum).
- FSM, address counter and timeout counter stay in imem_loader_v.

Test Plan:
- Frame A5,02,00,13,05,10,00,93,05,20,00,CSUM=0xE0 → writes addr0=0x00100513, addr1=0x00200593; load_done pulse; cpu_hold 1→0; words_loaded=2.
- Same frame with CSUM=0x00 → both writes occur, load_err pulse, err_code=2, cpu_hold stays 1.
- A5,00,00,00 → no imem_we; load_done; words_loaded=0. With N=0x0401 (ADDR_W=10) → ERROR code 1 immediately after LEN_HI, no writes.
- Stall rx_valid for TIMEOUT_CYCLES (set to 16) mid-DATA → load_err exactly at cycle 16 after the last byte, err_code=3.
- Back-to-back bytes with rx_valid held high → one word per 4 cycles, imem_we width 1, no dropped bytes. Then assert reset mid-frame → state IDLE, outputs zero, no further writes.
- Garbage bytes (0x00, 0xFF) before SYNC → ignored; frame then loads normally.
